// File: rtl/router_pkg.sv
// Shared types and constants for the mesh router output-port arbiter.
package router_pkg;

  localparam int unsigned N_REQ      = 5;
  localparam int unsigned PACK_WIDTH = 64;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned SUM_W      = IDX_W + 1;

  localparam logic [IDX_W-1:0] PORT_UP    = 3'd0;
  localparam logic [IDX_W-1:0] PORT_DOWN  = 3'd1;
  localparam logic [IDX_W-1:0] PORT_LEFT  = 3'd2;
  localparam logic [IDX_W-1:0] PORT_RIGHT = 3'd3;
  localparam logic [IDX_W-1:0] PORT_LOCAL = 3'd4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [3:0]  src_addr;
    logic [3:0]  dest_addr;
    logic [2:0]  pkt_type;
    logic [12:0] rsvd;
    logic [39:0] payload;
  } packet_t;

  // Reduce a sum of two in-range indices back into 0..N_REQ-1.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [SUM_W-1:0] x);
    if (x >= SUM_W'(N_REQ)) begin
      return IDX_W'(x - SUM_W'(N_REQ));
    end
    return IDX_W'(x);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority picker: first valid index at or after start, wrapping modulo N_REQ.
module rr_pick
  import router_pkg::*;
(
  input  logic [N_REQ-1:0] valid,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk offsets from farthest to nearest so the nearest valid index wins.
  always_comb begin
    idx = start;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (valid[wrap_idx(SUM_W'(start) + SUM_W'(i))]) begin
        idx = wrap_idx(SUM_W'(start) + SUM_W'(i));
      end
    end
  end

  assign any = |valid;

endmodule

// File: rtl/router_port_arbiter.sv
// Round-robin output-port arbiter with bounded burst hold and a one-entry output register.
// Optional per-requester grant counters are enabled by ROUTER_ARB_STATS_EN.
module router_port_arbiter
  import router_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*PACK_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic                        out_valid,
  output logic [PACK_WIDTH-1:0]       out_data,
  input  logic                        out_ready,
  output logic [IDX_W-1:0]            out_src
`ifdef ROUTER_ARB_STATS_EN
  ,
  output logic [N_REQ*CNT_WIDTH-1:0]  grant_count
`endif
);

  localparam int unsigned      BURST_W    = 4;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] HOLDER_RST = PORT_LOCAL;

  packet_t [N_REQ-1:0] req_pkt;

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   holder_q, holder_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               out_valid_d;
  packet_t            out_data_d;
  logic [IDX_W-1:0]   out_src_d;

  logic               load;
  logic               keep;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   scan_start;
  logic [IDX_W-1:0]   scan_idx;
  logic               scan_any;

  assign req_pkt    = req_data;
  assign scan_start = wrap_idx(SUM_W'(holder_q) + SUM_W'(1));

  rr_pick u_pick (
    .valid (req_valid),
    .start (scan_start),
    .idx   (scan_idx),
    .any   (scan_any)
  );

  // Next-state, winner selection and the combinational accept strobe.
  always_comb begin
    state_d     = state_q;
    holder_d    = holder_q;
    burst_d     = burst_q;
    out_valid_d = out_valid;
    out_data_d  = packet_t'(out_data);
    out_src_d   = out_src;
    req_ready   = '0;

    load = !out_valid || out_ready;
    keep = (state_q == HOLD) && req_valid[holder_q] && (burst_q < BURST_LAST);
    win  = keep ? holder_q : scan_idx;

    if (!rst && load) begin
      if (scan_any) begin
        req_ready[win] = 1'b1;
        out_valid_d    = 1'b1;
        out_data_d     = req_pkt[win];
        out_src_d      = win;
        state_d        = HOLD;
        if (keep) begin
          burst_d = burst_q + BURST_W'(1);
        end else begin
          burst_d  = '0;
          holder_d = scan_idx;
        end
      end else begin
        // Holder is kept so the rotation resumes where it left off.
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      holder_q  <= HOLDER_RST;
      burst_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else begin
      state_q   <= state_d;
      holder_q  <= holder_d;
      burst_q   <= burst_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_src   <= out_src_d;
    end
  end

`ifdef ROUTER_ARB_STATS_EN
  logic [N_REQ-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Saturating per-requester accept counters.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (req_ready[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_count = cnt_q;
`endif

endmodule

// File: tb/tb_router_port_arbiter.sv
// Bench for router_port_arbiter: two instances (MAX_BURST=1 and 4) checked against a behavioural model.
module tb_router_port_arbiter;

  localparam int NR  = 5;
  localparam int PW  = 64;
  localparam int CW  = 16;
  localparam int MB0 = 1;
  localparam int MB1 = 4;

  logic clk = 1'b0;
  logic rst;

  logic [NR-1:0]    valid [2];
  logic [NR*PW-1:0] data  [2];
  logic             ordy  [2];
  logic [NR-1:0]    ready [2];
  logic             ov    [2];
  logic [PW-1:0]    od    [2];
  logic [2:0]       os    [2];
`ifdef ROUTER_ARB_STATS_EN
  logic [NR*CW-1:0] gc    [2];
`endif

  int n_err = 0;
  int n_chk = 0;

  // Behavioural model state
  bit          m_ov     [2];
  logic [63:0] m_od     [2];
  int          m_os     [2];
  int          m_last   [2];
  int          m_run    [2];
  bit          m_active [2];
  int          m_cnt    [2][NR];
  int          acc      [2];
  int          wait_cnt [2][NR];

  always #5 clk = ~clk;

  router_port_arbiter #(.MAX_BURST(MB0), .CNT_WIDTH(CW)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(valid[0]), .req_data(data[0]), .req_ready(ready[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_ready(ordy[0]), .out_src(os[0])
`ifdef ROUTER_ARB_STATS_EN
    , .grant_count(gc[0])
`endif
  );

  router_port_arbiter #(.MAX_BURST(MB1), .CNT_WIDTH(CW)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(valid[1]), .req_data(data[1]), .req_ready(ready[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_ready(ordy[1]), .out_src(os[1])
`ifdef ROUTER_ARB_STATS_EN
    , .grant_count(gc[1])
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int mb(input int d);
    return (d == 0) ? MB0 : MB1;
  endfunction

  // Winner the rules imply for the current inputs, or -1 when nothing is accepted.
  function automatic int exp_winner(input int d);
    int c;
    if (rst) return -1;
    if (m_ov[d] && !ordy[d]) return -1;
    if (valid[d] == '0) return -1;
    if (m_active[d] && valid[d][m_last[d]] && (m_run[d] < mb(d))) return m_last[d];
    for (int k = 1; k <= NR; k++) begin
      c = (m_last[d] + k) % NR;
      if (valid[d][c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset(input int d);
    m_ov[d] = 0; m_od[d] = '0; m_os[d] = 0;
    m_last[d] = NR - 1; m_run[d] = 0; m_active[d] = 0;
    for (int i = 0; i < NR; i++) m_cnt[d][i] = 0;
  endtask

  task automatic model_update(input int d, input int w);
    if (rst) begin
      model_reset(d);
    end else if (!m_ov[d] || ordy[d]) begin
      if (w < 0) begin
        m_ov[d] = 0;
        m_active[d] = 0;
      end else begin
        // m_run counts consecutive grants to the current holder, 1-based.
        if (m_active[d] && w == m_last[d] && m_run[d] < mb(d)) m_run[d]++;
        else m_run[d] = 1;
        m_last[d] = w;
        m_active[d] = 1;
        m_ov[d] = 1;
        m_od[d] = data[d][w*PW +: PW];
        m_os[d] = w;
        if (m_cnt[d][w] < 65535) m_cnt[d][w]++;
      end
    end
  endtask

  // One clock: check at negedge, update model at posedge, return #1 later.
  task automatic step();
    int w [2];
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      w[d] = exp_winner(d);
      check($sformatf("d%0d_req_ready", d), 64'(ready[d]), (w[d] >= 0) ? (64'd1 << w[d]) : 64'd0);
      check($sformatf("d%0d_out_valid", d), 64'(ov[d]), 64'(m_ov[d]));
      check($sformatf("d%0d_out_data", d), od[d], m_od[d]);
      check($sformatf("d%0d_out_src", d), 64'(os[d]), 64'(m_os[d]));
`ifdef ROUTER_ARB_STATS_EN
      for (int i = 0; i < NR; i++)
        check($sformatf("d%0d_grant_count%0d", d, i), 64'(gc[d][i*CW +: CW]), 64'(m_cnt[d][i]));
`endif
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      model_update(d, w[d]);
      acc[d] = w[d];
    end
    #1;
  endtask

  task automatic set_all(input logic [NR-1:0] v, input logic r);
    for (int d = 0; d < 2; d++) begin
      valid[d] = v;
      ordy[d]  = r;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  int seq_rr0 [7] = '{0, 1, 2, 3, 4, 0, 1};
  int seq_rr1 [7] = '{0, 0, 0, 0, 1, 1, 1};
  int seq_bst [9] = '{1, 1, 1, 1, 3, 3, 3, 3, 1};

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      valid[d] = '0; ordy[d] = 1'b1;
      for (int i = 0; i < NR; i++) data[d][i*PW +: PW] = {32'hC0DE0000, 32'(i)};
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_reset(d);
    #1;
    do_reset();

    // Single request
    for (int d = 0; d < 2; d++) data[d][63:0] = 64'hA5;
    set_all(5'b00001, 1'b1);
    step();
    check("single_out_valid", 64'(ov[0]), 64'd1);
    check("single_out_data", od[0], 64'hA5);
    check("single_out_src", 64'(os[0]), 64'd0);
    set_all(5'b00000, 1'b1);
    step();

    // Continuous all-valid: pure round-robin vs burst of 4
    do_reset();
    set_all(5'b11111, 1'b1);
    for (int k = 0; k < 7; k++) begin
      step();
      check($sformatf("rr_seq%0d", k), 64'(os[0]), 64'(seq_rr0[k]));
      check($sformatf("burst_all_seq%0d", k), 64'(os[1]), 64'(seq_rr1[k]));
    end

    // Reset while the output register is full
    do_reset();
    check("rst_out_valid", 64'(ov[1]), 64'd0);
    check("rst_out_src", 64'(os[1]), 64'd0);
`ifdef ROUTER_ARB_STATS_EN
    check("rst_grant_count", 64'(gc[1]), 64'd0);
`endif
    step();
    check("post_rst_winner0", 64'(os[0]), 64'd0);
    check("post_rst_winner1", 64'(os[1]), 64'd0);

    // Burst hold between requesters 1 and 3
    do_reset();
    set_all(5'b01010, 1'b1);
    for (int k = 0; k < 9; k++) begin
      step();
      check($sformatf("burst_seq%0d", k), 64'(os[1]), 64'(seq_bst[k]));
    end

    // Backpressure with everyone requesting
    set_all(5'b11111, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp_ready%0d", k), 64'(ready[1]), 64'd0);
      step();
    end
    set_all(5'b11111, 1'b1);
    for (int k = 0; k < 3; k++) step();

    // Wrap through index 4 and idle retention
    do_reset();
    set_all(5'b10000, 1'b1);
    step();
    check("wrap_src4", 64'(os[0]), 64'd4);
    set_all(5'b00000, 1'b1);
    step();
    step();
    check("idle_out_valid", 64'(ov[1]), 64'd0);
    check("idle_src_hold", 64'(os[1]), 64'd4);
    set_all(5'b10001, 1'b1);
    step();
    check("wrap_after_idle0", 64'(os[0]), 64'd0);
    check("wrap_after_idle1", 64'(os[1]), 64'd0);

    // Randomized traffic with fairness bound
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NR; i++) wait_cnt[d][i] = 0;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 399) == 0);
      step();
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < NR; i++) begin
          if (rst) wait_cnt[d][i] = 0;
          else if (acc[d] >= 0 && valid[d][i]) begin
            wait_cnt[d][i]++;
            if (acc[d] == i) begin
              check($sformatf("d%0d_fair%0d", d, i), 64'(wait_cnt[d][i] <= (NR - 1) * mb(d) + 1), 64'd1);
              wait_cnt[d][i] = 0;
            end
          end
          if (!(valid[d][i] && acc[d] != i)) begin
            valid[d][i] = ($urandom_range(0, 99) < 45);
            data[d][i*PW +: PW] = {$urandom, $urandom};
          end
        end
        ordy[d] = ($urandom_range(0, 99) < 75);
      end
    end
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
